// File: rtl/sparc_ifu_wayrep_sel_if.sv
// rtl/sparc_ifu_wayrep_sel_if.sv - request, tag valid-bit, LFSR and fill-pipe signals of the icache victim-way allocator
//
// Ports (slave = allocator side):
//   req_vld/req_idx/req_rdy      miss allocation request
//   vbits_vld/vbits              tag-array valid bits for the captured set
//   rand_way/lfsr_advance        replacement LFSR way and its step strobe
//   alloc_vld/alloc_idx/alloc_way/alloc_inv/alloc_ack  allocation to fill pipe
//   flush                        abort outstanding request
//   rand_cnt                     saturating count of random victim picks
interface sparc_ifu_wayrep_sel_if #(
  parameter int IDX_W = 7,
  parameter int CNT_W = 8
);
  logic             req_vld;
  logic [IDX_W-1:0] req_idx;
  logic             req_rdy;
  logic             vbits_vld;
  logic [3:0]       vbits;
  logic [1:0]       rand_way;
  logic             lfsr_advance;
  logic             alloc_vld;
  logic [IDX_W-1:0] alloc_idx;
  logic [1:0]       alloc_way;
  logic             alloc_inv;
  logic             alloc_ack;
  logic             flush;
  logic [CNT_W-1:0] rand_cnt;

  modport master (
    output req_vld, req_idx, vbits_vld, vbits, rand_way, alloc_ack, flush,
    input  req_rdy, lfsr_advance, alloc_vld, alloc_idx, alloc_way, alloc_inv, rand_cnt
  );

  modport slave (
    input  req_vld, req_idx, vbits_vld, vbits, rand_way, alloc_ack, flush,
    output req_rdy, lfsr_advance, alloc_vld, alloc_idx, alloc_way, alloc_inv, rand_cnt
  );
endinterface

// File: rtl/sparc_ifu_wayrep_sel.sv
// rtl/sparc_ifu_wayrep_sel.sv - icache fill victim-way allocator (lowest invalid way, else LFSR way)
//
// Ports:
//   clk     core clock
//   arst_l  asynchronous active-low reset
//   bus     sparc_ifu_wayrep_sel_if.slave (request, valid bits, LFSR, fill-pipe handshake, stats)
//
// Optional macro SPARC_IFU_WAYREP_RR_EN: all-valid victims come from a 2-bit
// round-robin pointer instead of rand_way; lfsr_advance is then tied low.
module sparc_ifu_wayrep_sel #(
  parameter int IDX_W = 7,
  parameter int CNT_W = 8
) (
  input logic                   clk,
  input logic                   arst_l,
  sparc_ifu_wayrep_sel_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_V = 2'd1,
    ALLOC  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             alloc_vld_q, alloc_vld_d;
  logic [IDX_W-1:0] alloc_idx_q, alloc_idx_d;
  logic [1:0]       alloc_way_q, alloc_way_d;
  logic             alloc_inv_q, alloc_inv_d;
  logic [CNT_W-1:0] rand_cnt_q, rand_cnt_d;

  logic       all_valid;
  logic [1:0] inv_way;
  logic [1:0] pick_way;
  logic       pick_fire;

  assign all_valid = &bus.vbits;
  // A pick happens only on valid bits arriving while waiting; flush kills it.
  assign pick_fire = (state_q == WAIT_V) && bus.vbits_vld && !bus.flush;

  // Lowest-numbered invalid way; value is don't-care when all ways are valid.
  always_comb begin
    inv_way = 2'd3;
    if (!bus.vbits[0])      inv_way = 2'd0;
    else if (!bus.vbits[1]) inv_way = 2'd1;
    else if (!bus.vbits[2]) inv_way = 2'd2;
  end

`ifdef SPARC_IFU_WAYREP_RR_EN
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic       unused_rand_way;

  assign unused_rand_way  = ^bus.rand_way;
  assign pick_way         = all_valid ? rr_ptr_q : inv_way;
  assign bus.lfsr_advance = 1'b0;

  // Pointer moves only on an all-valid pick.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (pick_fire && all_valid) rr_ptr_d = rr_ptr_q + 2'd1;
  end

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) rr_ptr_q <= 2'd0;
    else         rr_ptr_q <= rr_ptr_d;
  end
`else
  assign pick_way = all_valid ? bus.rand_way : inv_way;
  // Combinational so the LFSR steps at the end of the very cycle its way was
  // consumed; WAIT_V is always left on a pick, so this cannot fire twice in a row.
  assign bus.lfsr_advance = pick_fire && all_valid;
`endif

  always_comb begin
    state_d     = state_q;
    alloc_vld_d = alloc_vld_q;
    alloc_idx_d = alloc_idx_q;
    alloc_way_d = alloc_way_q;
    alloc_inv_d = alloc_inv_q;
    rand_cnt_d  = rand_cnt_q;
    if (bus.flush) begin
      state_d     = IDLE;
      alloc_vld_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_vld) begin
            alloc_idx_d = bus.req_idx;
            state_d     = WAIT_V;
          end
        end
        WAIT_V: begin
          if (bus.vbits_vld) begin
            alloc_way_d = pick_way;
            alloc_inv_d = !all_valid;
            alloc_vld_d = 1'b1;
            state_d     = ALLOC;
            if (all_valid && (rand_cnt_q != {CNT_W{1'b1}}))
              rand_cnt_d = rand_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ALLOC: begin
          if (bus.alloc_ack) begin
            alloc_vld_d = 1'b0;
            state_d     = IDLE;
          end
        end
        default: begin
          alloc_vld_d = 1'b0;
          state_d     = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      state_q     <= IDLE;
      alloc_vld_q <= 1'b0;
      alloc_idx_q <= '0;
      alloc_way_q <= 2'd0;
      alloc_inv_q <= 1'b0;
      rand_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      alloc_vld_q <= alloc_vld_d;
      alloc_idx_q <= alloc_idx_d;
      alloc_way_q <= alloc_way_d;
      alloc_inv_q <= alloc_inv_d;
      rand_cnt_q  <= rand_cnt_d;
    end
  end

  assign bus.req_rdy   = (state_q == IDLE);
  assign bus.alloc_vld = alloc_vld_q;
  assign bus.alloc_idx = alloc_idx_q;
  assign bus.alloc_way = alloc_way_q;
  assign bus.alloc_inv = alloc_inv_q;
  assign bus.rand_cnt  = rand_cnt_q;

endmodule

// File: tb/tb_sparc_ifu_wayrep_sel.sv
// tb/tb_sparc_ifu_wayrep_sel.sv - self-checking bench for sparc_ifu_wayrep_sel
module tb_sparc_ifu_wayrep_sel;
  localparam int IDX_W = 7;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic arst_l = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cnt_m = 0;
  int   ptr_m = 0;

  always #5 clk = ~clk;

  sparc_ifu_wayrep_sel_if #(.IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

  sparc_ifu_wayrep_sel #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .arst_l (arst_l),
    .bus    (bus)
  );

`ifdef SPARC_IFU_WAYREP_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // Reference victim: first invalid way, else the random source.
  function automatic logic [1:0] model_way(input logic [3:0] vb, input logic [1:0] rw);
    for (int n = 0; n < 4; n++)
      if (!vb[n]) return 2'(n);
    return RR ? 2'(ptr_m) : rw;
  endfunction

  task automatic idle_inputs();
    bus.req_vld   = 1'b0;
    bus.req_idx   = '0;
    bus.vbits_vld = 1'b0;
    bus.vbits     = 4'h0;
    bus.rand_way  = 2'd0;
    bus.alloc_ack = 1'b0;
    bus.flush     = 1'b0;
  endtask

  // Entered and left at a negedge with the DUT idle.
  task automatic run_txn(input logic [6:0] idx, input logic [3:0] vb, input logic [1:0] rw,
                         input int wait_v, input int bp);
    logic [1:0] exp_way;
    logic       exp_inv;
    logic       exp_adv;
    total++;
    if (bus.req_rdy !== 1'b1) begin bad++; $display("FAIL txn_req_rdy_idle got=%0b want=1", bus.req_rdy); end
    bus.req_vld = 1'b1;
    bus.req_idx = idx;
    @(negedge clk);
    bus.req_vld = 1'b0;
    bus.req_idx = 7'($urandom);
    total++;
    if (bus.req_rdy !== 1'b0) begin bad++; $display("FAIL txn_req_rdy_wait got=%0b want=0", bus.req_rdy); end
    for (int i = 0; i < wait_v; i++) begin
      bus.vbits    = 4'($urandom);
      bus.rand_way = 2'($urandom);
      #1;
      total++;
      if (bus.lfsr_advance !== 1'b0 || bus.alloc_vld !== 1'b0) begin
        bad++; $display("FAIL txn_wait_quiet adv=%0b vld=%0b want=0,0", bus.lfsr_advance, bus.alloc_vld);
      end
      @(negedge clk);
    end
    exp_way = model_way(vb, rw);
    exp_inv = (vb != 4'hF);
    exp_adv = !exp_inv && !RR;
    bus.vbits_vld = 1'b1;
    bus.vbits     = vb;
    bus.rand_way  = rw;
    #1;
    total++;
    if (bus.lfsr_advance !== exp_adv) begin bad++; $display("FAIL txn_lfsr_adv got=%0b want=%0b", bus.lfsr_advance, exp_adv); end
    if (!exp_inv) begin
      if (cnt_m < CMAX) cnt_m++;
      ptr_m = (ptr_m + 1) % 4;
    end
    @(negedge clk);
    bus.vbits_vld = 1'b0;
    bus.rand_way  = 2'($urandom);
    for (int k = 0; k <= bp; k++) begin
      total++;
      if (bus.alloc_vld !== 1'b1 || bus.alloc_idx !== idx || bus.alloc_way !== exp_way ||
          bus.alloc_inv !== exp_inv || bus.rand_cnt !== CNT_W'(cnt_m)) begin
        bad++;
        $display("FAIL txn_alloc vld=%0b idx=%0h way=%0d inv=%0b cnt=%0d want 1,%0h,%0d,%0b,%0d",
                 bus.alloc_vld, bus.alloc_idx, bus.alloc_way, bus.alloc_inv, bus.rand_cnt,
                 idx, exp_way, exp_inv, cnt_m);
      end
      if (k == bp) begin
        bus.alloc_ack = 1'b1;
        bus.req_vld   = 1'b0;
        bus.vbits_vld = 1'b0;
      end else begin
        // Stray request/valid bits while allocating must be ignored.
        bus.alloc_ack = 1'b0;
        bus.req_vld   = 1'($urandom);
        bus.vbits_vld = 1'($urandom);
        bus.vbits     = 4'hF;
      end
      #1;
      total++;
      if (bus.lfsr_advance !== 1'b0 || bus.req_rdy !== 1'b0) begin
        bad++; $display("FAIL txn_alloc_quiet adv=%0b rdy=%0b want=0,0", bus.lfsr_advance, bus.req_rdy);
      end
      @(negedge clk);
    end
    idle_inputs();
    total++;
    if (bus.alloc_vld !== 1'b0 || bus.req_rdy !== 1'b1) begin
      bad++; $display("FAIL txn_after_ack vld=%0b rdy=%0b want=0,1", bus.alloc_vld, bus.req_rdy);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    arst_l = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (bus.req_rdy !== 1'b1 || bus.alloc_vld !== 1'b0 || bus.lfsr_advance !== 1'b0 ||
        bus.rand_cnt !== '0 || bus.alloc_idx !== '0 || bus.alloc_way !== 2'd0 || bus.alloc_inv !== 1'b0) begin
      bad++;
      $display("FAIL reset rdy=%0b vld=%0b adv=%0b cnt=%0d idx=%0h way=%0d inv=%0b want 1,0,0,0,0,0,0",
               bus.req_rdy, bus.alloc_vld, bus.lfsr_advance, bus.rand_cnt, bus.alloc_idx,
               bus.alloc_way, bus.alloc_inv);
    end
    cnt_m  = 0;
    ptr_m  = 0;
    arst_l = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_invalid_pick();
    run_txn(7'h15, 4'b1011, 2'($urandom), 2, 1);
  endtask

  task automatic test_random_backpressure();
    run_txn(7'h2A, 4'hF, 2'd3, 1, 5);
  endtask

  task automatic test_flush_collision();
    bus.req_vld = 1'b1;
    bus.req_idx = 7'h33;
    @(negedge clk);
    bus.req_vld   = 1'b0;
    bus.vbits_vld = 1'b1;
    bus.vbits     = 4'hF;
    bus.rand_way  = 2'd1;
    bus.flush     = 1'b1;
    #1;
    total++;
    if (bus.lfsr_advance !== 1'b0) begin bad++; $display("FAIL flush_vbits_adv got=%0b want=0", bus.lfsr_advance); end
    @(negedge clk);
    idle_inputs();
    total++;
    if (bus.req_rdy !== 1'b1 || bus.alloc_vld !== 1'b0 || bus.rand_cnt !== CNT_W'(cnt_m)) begin
      bad++; $display("FAIL flush_vbits_state rdy=%0b vld=%0b cnt=%0d want 1,0,%0d",
                      bus.req_rdy, bus.alloc_vld, bus.rand_cnt, cnt_m);
    end
    @(negedge clk);
    total++;
    if (bus.alloc_vld !== 1'b0) begin bad++; $display("FAIL flush_vbits_hold vld=%0b want=0", bus.alloc_vld); end
  endtask

  task automatic test_flush_alloc();
    bus.req_vld = 1'b1;
    bus.req_idx = 7'h41;
    @(negedge clk);
    bus.req_vld   = 1'b0;
    bus.vbits_vld = 1'b1;
    bus.vbits     = 4'b0111;
    @(negedge clk);
    bus.vbits_vld = 1'b0;
    total++;
    if (bus.alloc_vld !== 1'b1 || bus.alloc_way !== 2'd3 || bus.alloc_inv !== 1'b1) begin
      bad++; $display("FAIL flush_alloc_pre vld=%0b way=%0d inv=%0b want 1,3,1", bus.alloc_vld, bus.alloc_way, bus.alloc_inv);
    end
    // Flush beats ack and a coincident new request.
    bus.flush     = 1'b1;
    bus.alloc_ack = 1'b1;
    bus.req_vld   = 1'b1;
    @(negedge clk);
    idle_inputs();
    total++;
    if (bus.alloc_vld !== 1'b0 || bus.req_rdy !== 1'b1) begin
      bad++; $display("FAIL flush_alloc vld=%0b rdy=%0b want 0,1", bus.alloc_vld, bus.req_rdy);
    end
    @(negedge clk);
    total++;
    if (bus.req_rdy !== 1'b1) begin bad++; $display("FAIL flush_req_dropped rdy=%0b want=1", bus.req_rdy); end
  endtask

  task automatic test_random_traffic();
    for (int t = 0; t < 150; t++) begin
      logic [3:0] vb;
      vb = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      run_txn(7'($urandom), vb, 2'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 6; t++)
      run_txn(7'($urandom), (t % 2 == 0) ? 4'hF : 4'b1110, 2'($urandom), 0, 0);
  endtask

  task automatic test_saturation();
    for (int t = 0; t < 260; t++)
      run_txn(7'($urandom), 4'hF, 2'($urandom), 0, 0);
    total++;
    if (bus.rand_cnt !== CNT_W'(CMAX)) begin bad++; $display("FAIL saturation cnt=%0d want=%0d", bus.rand_cnt, CMAX); end
  endtask

  task automatic test_reset_mid();
    bus.req_vld = 1'b1;
    bus.req_idx = 7'h7F;
    @(negedge clk);
    bus.req_vld   = 1'b0;
    bus.vbits_vld = 1'b1;
    bus.vbits     = 4'hF;
    @(negedge clk);
    idle_inputs();
    #2 arst_l = 1'b0;
    #1;
    total++;
    if (bus.alloc_vld !== 1'b0 || bus.req_rdy !== 1'b1 || bus.rand_cnt !== '0 || bus.alloc_idx !== '0) begin
      bad++; $display("FAIL reset_mid vld=%0b rdy=%0b cnt=%0d idx=%0h want 0,1,0,0",
                      bus.alloc_vld, bus.req_rdy, bus.rand_cnt, bus.alloc_idx);
    end
    cnt_m = 0;
    ptr_m = 0;
    @(negedge clk);
    arst_l = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rr_sequence();
    for (int t = 0; t < 5; t++)
      run_txn(7'($urandom), 4'hF, 2'($urandom), 1, 0);
  endtask

  initial begin
    test_reset();
    test_invalid_pick();
    test_random_backpressure();
    test_flush_collision();
    test_flush_alloc();
    test_back_to_back();
    test_random_traffic();
    test_reset_mid();
    test_rr_sequence();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sparc_ifu_wayrep_sel.md
Name: sparc_ifu_wayrep_sel

Overview:
- Icache fill victim-way allocator. It consumes the 2-bit pseudo-random way from the IFU replacement LFSR and drives that LFSR's advance strobe.
- Per icache miss: accepts the set index, waits for that set's valid bits from the tag array, and picks a victim way. The victim is the lowest invalid way, else the LFSR way.
- Presents the allocation to the fill pipe with a valid/ack handshake.

Parameters:
IDX_W, 7, set index width
CNT_W, 8, width of saturating random-victim statistics counter

Ports:
clk  in  1  core clock
arst_l  in  1  asynchronous active-low reset
req_vld  in  1  miss allocation request
req_idx  in  IDX_W  set index of miss
req_rdy  out  1  block can accept request (state==IDLE)
vbits_vld  in  1  tag-array valid bits for captured index are present this cycle
vbits  in  4  per-way valid bits, bit n = way n
rand_way  in  2  current LFSR way selection
lfsr_advance  out  1  one-cycle strobe to step LFSR
alloc_vld  out  1  allocation valid to fill pipe
alloc_idx  out  IDX_W  captured set index
alloc_way  out  2  chosen victim way
alloc_inv  out  1  victim was an invalid way (no eviction)
alloc_ack  in  1  fill pipe consumed allocation
flush  in  1  abort outstanding request (thread flush / redirect)
rand_cnt  out  CNT_W  count of random (all-valid) victim picks, saturating

Behaviour:
- Reset (arst_l=0, async):
  - state=IDLE.
  - alloc_vld, alloc_idx, alloc_way, alloc_inv, rand_cnt all 0.
  - lfsr_advance=0; req_rdy=1 (decoded from IDLE).
- States: IDLE, WAIT_V, ALLOC.
- IDLE:
  - req_rdy=1.
  - req_vld & ~flush: capture req_idx into alloc_idx, go to WAIT_V.
- WAIT_V:
  - req_rdy=0; waits any number of cycles for vbits_vld.
  - On vbits_vld & ~flush:
    - If any vbits bit is 0: alloc_way=lowest index n with vbits[n]=0, alloc_inv=1, lfsr_advance=0.
    - Else (vbits=4'b1111): alloc_way=rand_way sampled this cycle, alloc_inv=0, lfsr_advance=1 this same cycle only, rand_cnt+=1 (holds at 2^CNT_W-1).
    - Go to ALLOC; alloc_vld=1 from the next cycle.
- ALLOC:
  - alloc_vld=1.
  - alloc_idx, alloc_way and alloc_inv stay stable until the cycle alloc_ack=1.
  - On alloc_ack: alloc_vld=0 next cycle, go to IDLE.
  - A new request is accepted no earlier than the cycle after the return to IDLE, so the minimum request-to-request spacing is 3 cycles.
- Latency: vbits_vld cycle → alloc_vld 1 cycle later. Same-cycle ack is legal; alloc_vld is high for exactly 1 cycle.
- flush:
  - Any state: next state is IDLE and alloc_vld goes to 0 next cycle.
  - flush beats alloc_ack, vbits_vld and req_vld in the same cycle.
  - lfsr_advance is forced 0 and rand_cnt does not increment when flush coincides with vbits_vld.
- vbits_vld in IDLE or ALLOC is ignored. req_vld outside IDLE is ignored (req_rdy=0).
- lfsr_advance never asserts in two consecutive cycles.
- Reset mid-operation: immediate return to reset values; any pending allocation is dropped.

Optional Feature:
Macro SPARC_IFU_WAYREP_RR_EN.
- Defined: adds a 2-bit round-robin pointer (reset 0).
  - When all ways are valid, alloc_way=pointer and the pointer increments mod 4 (3→0). This is the only event that moves the pointer.
  - rand_way is ignored and lfsr_advance is tied 0; rand_cnt still counts these picks.
- Undefined: LFSR-based selection exactly as in Behaviour; no pointer logic present.

Test Plan:
- Reset then idle: arst_l low → req_rdy=1, alloc_vld=0, lfsr_advance=0, rand_cnt=0.
- Invalid way pick: req_idx=7'h15, then vbits=4'b1011 → alloc_way=2, alloc_inv=1, alloc_idx=7'h15, lfsr_advance never asserted.
- Random pick with backpressure: vbits=4'b1111, rand_way=3 → lfsr_advance pulses 1 cycle, alloc_way=3, alloc_inv=0, rand_cnt=1. Hold alloc_ack=0 for 5 cycles → outputs stable; ack → IDLE next cycle.
- Flush collision: flush and vbits_vld=1 with vbits=4'hF in the same cycle → IDLE next cycle, lfsr_advance=0, rand_cnt unchanged, alloc_vld stays 0.
- Saturation: with CNT_W=8, run 260 all-valid allocations → rand_cnt=255.
- With SPARC_IFU_WAYREP_RR_EN, 5 all-valid allocations → alloc_way sequence 0,1,2,3,0; lfsr_advance always 0.
